// File: rtl/test_uart.sv
`timescale 1ns/1ps
// test_uart: UART transmitter with its receiver looped back from serial_out.
// Define UART_PARITY_EN to add an even-parity bit between data and stop.
module test_uart #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int CLOCKS_PER_BIT   = 868
) (
    input  logic                        clk,
    input  logic                        reset_tx,
    input  logic                        reset_rx,
    input  logic                        enable,
    input  logic [INPUT_DATA_WIDTH-1:0] i_data,
    output logic                        serial_out,
    output logic                        o_busy,
    output logic [INPUT_DATA_WIDTH-1:0] received_data,
    output logic                        data_is_valid,
    output logic                        rx_error
);

    localparam int W  = INPUT_DATA_WIDTH;
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    localparam logic [CW-1:0] LP_LAST  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] LP_HALF  = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] LP_BLAST = IW'(W - 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t       r_tx_state;
    logic [CW-1:0]   r_tx_cnt;
    logic [IW-1:0]   r_tx_idx;
    logic [W-1:0]    r_tx_data;
    logic            r_tx;
    logic            r_busy;
`ifdef UART_PARITY_EN
    logic            r_tx_par;
`endif

    logic            w_tx_end;
    logic [W-1:0]    w_tx_shift;

    assign w_tx_end   = (r_tx_cnt == LP_LAST);
    assign w_tx_shift = r_tx_data >> 1;

    // Transmit framer: start bit, data LSB first, optional parity, stop bit
    always_ff @(posedge clk or posedge reset_tx) begin
        if (reset_tx) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_data  <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_cnt <= '0;
                    r_tx_idx <= '0;
                    if (enable) begin
                        r_tx_data  <= i_data;
`ifdef UART_PARITY_EN
                        r_tx_par   <= ^i_data;
`endif
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_tx_state <= TX_START;
                    end else begin
                        r_tx   <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                TX_START: begin
                    if (w_tx_end) begin
                        r_tx_cnt   <= '0;
                        r_tx       <= r_tx_data[0];
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (w_tx_end) begin
                        r_tx_cnt <= '0;
                        if (r_tx_idx == LP_BLAST) begin
                            r_tx_idx   <= '0;
`ifdef UART_PARITY_EN
                            r_tx       <= r_tx_par;
                            r_tx_state <= TX_PARITY;
`else
                            r_tx       <= 1'b1;
                            r_tx_state <= TX_STOP;
`endif
                        end else begin
                            r_tx_idx  <= r_tx_idx + 1'b1;
                            r_tx_data <= w_tx_shift;
                            r_tx      <= w_tx_shift[0];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    if (w_tx_end) begin
                        r_tx_cnt   <= '0;
                        r_tx       <= 1'b1;
                        r_tx_state <= TX_STOP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
`endif
                TX_STOP: begin
                    if (w_tx_end) begin
                        r_tx_cnt <= '0;
                        // A held enable chains straight into the next start bit
                        if (enable) begin
                            r_tx_data  <= i_data;
`ifdef UART_PARITY_EN
                            r_tx_par   <= ^i_data;
`endif
                            r_tx       <= 1'b0;
                            r_tx_state <= TX_START;
                        end else begin
                            r_tx       <= 1'b1;
                            r_busy     <= 1'b0;
                            r_tx_state <= TX_IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign serial_out = r_tx;
    assign o_busy     = r_busy;

    // ---------------- receiver ----------------
    logic            w_rx_line;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_rx_prev;
    logic            w_fall;

    assign w_rx_line = r_tx;
    assign w_fall    = r_rx_prev & ~r_sync2;

    // Two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge clk or posedge reset_rx) begin
        if (reset_rx) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= w_rx_line;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    rx_state_t       r_rx_state;
    logic [CW-1:0]   r_rx_cnt;
    logic [IW-1:0]   r_rx_idx;
    logic [W-1:0]    r_rx_shift;
    logic [W-1:0]    r_rx_data;
    logic            r_rx_valid;
    logic            r_rx_err;
    logic            w_rx_end;
    logic [W:0]      w_rx_cat;
    logic            w_stop_ok;
`ifdef UART_PARITY_EN
    logic            r_par_err;
`endif

    assign w_rx_end = (r_rx_cnt == LP_LAST);
    assign w_rx_cat = {r_sync2, r_rx_shift};
`ifdef UART_PARITY_EN
    assign w_stop_ok = r_sync2 & ~r_par_err;
`else
    assign w_stop_ok = r_sync2;
`endif

    // Receive deframer sampling mid-bit, one-cycle valid/error strobes
    always_ff @(posedge clk or posedge reset_rx) begin
        if (reset_rx) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
`ifdef UART_PARITY_EN
            r_par_err  <= 1'b0;
`endif
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    r_rx_idx <= '0;
                    if (w_fall) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == LP_HALF) begin
                        r_rx_cnt   <= '0;
                        // A start bit that is high again was a glitch
                        r_rx_state <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_rx_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= w_rx_cat[W:1];
                        if (r_rx_idx == LP_BLAST) begin
                            r_rx_idx   <= '0;
`ifdef UART_PARITY_EN
                            r_rx_state <= RX_PARITY;
`else
                            r_rx_state <= RX_STOP;
`endif
                        end else begin
                            r_rx_idx <= r_rx_idx + 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (w_rx_end) begin
                        r_rx_cnt   <= '0;
                        r_par_err  <= r_sync2 ^ (^r_rx_shift);
                        r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (w_rx_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                        if (w_stop_ok) begin
                            r_rx_data  <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_rx_err <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign received_data = r_rx_data;
    assign data_is_valid = r_rx_valid;
    assign rx_error      = r_rx_err;

endmodule

// File: tb/tb_test_uart.sv
`timescale 1ns/1ps
// tb_test_uart: randomized frames against a frame-level model of the
// looped-back UART (bit timing, received word, strobe counts).
module tb_test_uart;

    localparam int CPB = 20;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int LAT = ((2 * FB - 1) * CPB) / 2 + 4;

    logic       clk = 1'b0;
    logic       reset_tx;
    logic       reset_rx;
    logic       enable;
    logic [7:0] i_data;
    logic       serial_out;
    logic       o_busy;
    logic [7:0] received_data;
    logic       data_is_valid;
    logic       rx_error;

    test_uart #(
        .INPUT_DATA_WIDTH(8),
        .CLOCKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .reset_tx(reset_tx),
        .reset_rx(reset_rx),
        .enable(enable),
        .i_data(i_data),
        .serial_out(serial_out),
        .o_busy(o_busy),
        .received_data(received_data),
        .data_is_valid(data_is_valid),
        .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_last = 8'h00;

    // Strobe recorder
    int n_valid = 0;
    int n_err = 0;
    int n_wide = 0;
    int last_vcyc = 0;
    logic [7:0] rx_log [0:63];
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;

    always @(negedge clk) begin
        if (data_is_valid === 1'b1) begin
            rx_log[n_valid[5:0]] <= received_data;
            n_valid <= n_valid + 1;
            last_vcyc <= cyc;
        end
        if (rx_error === 1'b1) n_err <= n_err + 1;
        if ((data_is_valid && prev_v) || (rx_error && prev_e))
            n_wide <= n_wide + 1;
        prev_v <= data_is_valid;
        prev_e <= rx_error;
    end

    function automatic logic [FB-1:0] frame_of(input logic [7:0] d);
`ifdef UART_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one frame and observes the line at every bit centre
    task automatic run_frame(input logic [7:0] d,
                             output logic [FB-1:0] bits,
                             output logic s0, output logic busy_all,
                             output logic busy_last,
                             output logic busy_after,
                             output int t0);
        @(negedge clk);
        i_data = d;
        enable = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        s0 = serial_out;
        busy_all = o_busy;
        @(negedge clk);
        enable = 1'b0;
        i_data = 8'($urandom);
        for (int k = 0; k < FB; k++) begin
            wait_cyc(t0 + k * CPB + CPB / 2);
            bits[k] = serial_out;
            busy_all = busy_all & o_busy;
            i_data = 8'($urandom);
        end
        wait_cyc(t0 + FB * CPB - 1);
        busy_last = o_busy;
        wait_cyc(t0 + FB * CPB);
        busy_after = o_busy;
    endtask

    task automatic test_reset();
        reset_tx = 1'b1;
        reset_rx = 1'b1;
        enable = 1'b0;
        i_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (serial_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_serial: got %b want 1", serial_out);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", o_busy);
        end
        checks++;
        if (received_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rxdata: got %h want 00", received_data);
        end
        checks++;
        if (data_is_valid !== 1'b0 || rx_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b%b want 00",
                     data_is_valid, rx_error);
        end
        @(negedge clk);
        reset_tx = 1'b0;
        reset_rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (serial_out !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_line: got %b/%b want 1/0",
                     serial_out, o_busy);
        end
    endtask

    task automatic test_frame(input logic [7:0] d, input string nm);
        logic [FB-1:0] bits;
        logic s0, ba, bl, bf;
        int t0, nv0, lat;
        nv0 = n_valid;
        run_frame(d, bits, s0, ba, bl, bf, t0);
        wait_cyc(t0 + FB * CPB + 2);
        checks++;
        if (bits !== frame_of(d)) begin
            errors++;
            $display("FAIL %s_bits: got %b want %b", nm, bits, frame_of(d));
        end
        checks++;
        if (s0 !== 1'b0 || ba !== 1'b1 || bl !== 1'b1) begin
            errors++;
            $display("FAIL %s_start_busy: got %b%b%b want 011",
                     nm, s0, ba, bl);
        end
        checks++;
        if (bf !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_drop: got %b want 0", nm, bf);
        end
        checks++;
        if (n_valid !== nv0 + 1) begin
            errors++;
            $display("FAIL %s_valid_count: got %0d want %0d",
                     nm, n_valid - nv0, 1);
        end else begin
            model_last = d;
            lat = last_vcyc - t0;
            checks++;
            if (rx_log[nv0[5:0]] !== d) begin
                errors++;
                $display("FAIL %s_rxdata: got %h want %h",
                         nm, rx_log[nv0[5:0]], d);
            end
            checks++;
            if (lat > LAT || lat < (FB - 1) * CPB) begin
                errors++;
                $display("FAIL %s_latency: got %0d want <= %0d",
                         nm, lat, LAT);
            end
        end
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 6; i++) begin
            test_frame(8'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [FB-1:0] f;
        int t0, nv0, drops, bad, rel;
        f = frame_of(8'hA3);
        nv0 = n_valid;
        drops = 0;
        bad = 0;
        @(negedge clk);
        i_data = 8'hA3;
        enable = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int c = t0; c < t0 + 3 * FB * CPB; c++) begin
            wait_cyc(c);
            rel = c - t0;
            if (o_busy !== 1'b1) drops++;
            if (rel % CPB == CPB / 2) begin
                if (serial_out !== f[(rel / CPB) % FB]) bad++;
            end
            if (rel == (3 * FB - 1) * CPB + CPB / 2) enable = 1'b0;
        end
        wait_cyc(t0 + 3 * FB * CPB);
        checks++;
        if (drops !== 0) begin
            errors++;
            $display("FAIL b2b_busy: got %0d low cycles want 0", drops);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL b2b_bits: got %0d bad bits want 0", bad);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy_end: got %b want 0", o_busy);
        end
        checks++;
        if (n_valid !== nv0 + 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 3", n_valid - nv0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_log[6'(nv0 + i)] !== 8'hA3) begin
                errors++;
                $display("FAIL b2b_data%0d: got %h want a3",
                         i, rx_log[6'(nv0 + i)]);
            end
        end
        model_last = 8'hA3;
    endtask

    task automatic test_tx_reset();
        logic [7:0] d, d2, seen;
        logic good;
        int t0, t1, nv0, ne0;
        d = 8'($urandom);
        seen = d | 8'hF8;
`ifdef UART_PARITY_EN
        good = (^seen) == 1'b1;
`else
        good = 1'b1;
`endif
        nv0 = n_valid;
        ne0 = n_err;
        @(negedge clk);
        i_data = d;
        enable = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        @(negedge clk);
        enable = 1'b0;
        wait_cyc(t0 + 4 * CPB + CPB / 4);
        reset_tx = 1'b1;
        #1;
        checks++;
        if (serial_out !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL txrst_now: got %b/%b want 1/0",
                     serial_out, o_busy);
        end
        wait_cyc(t0 + FB * CPB + 4);
        if (good) model_last = seen;
        checks++;
        if (n_valid - nv0 + n_err - ne0 !== 1) begin
            errors++;
            $display("FAIL txrst_strobes: got %0d want 1",
                     n_valid - nv0 + n_err - ne0);
        end
        checks++;
        if (received_data !== model_last) begin
            errors++;
            $display("FAIL txrst_rxdata: got %h want %h",
                     received_data, model_last);
        end
        d2 = 8'($urandom);
        @(negedge clk);
        reset_tx = 1'b0;
        i_data = d2;
        enable = 1'b1;
        @(posedge clk);
        #1;
        t1 = cyc;
        checks++;
        if (serial_out !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL txrst_first_edge: got %b/%b want 0/1",
                     serial_out, o_busy);
        end
        @(negedge clk);
        enable = 1'b0;
        wait_cyc(t1 + FB * CPB + 2);
        model_last = d2;
        checks++;
        if (received_data !== model_last) begin
            errors++;
            $display("FAIL txrst_next_frame: got %h want %h",
                     received_data, model_last);
        end
    endtask

    task automatic test_rx_reset();
        int t0, nv0, ne0;
        nv0 = n_valid;
        ne0 = n_err;
        @(negedge clk);
        i_data = 8'hA3;
        enable = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        @(negedge clk);
        enable = 1'b0;
        wait_cyc(t0 + 3 * CPB + CPB / 2);
        reset_rx = 1'b1;
        #1;
        model_last = 8'h00;
        checks++;
        if (received_data !== 8'h00) begin
            errors++;
            $display("FAIL rxrst_data: got %h want 00", received_data);
        end
        checks++;
        if (data_is_valid !== 1'b0 || rx_error !== 1'b0) begin
            errors++;
            $display("FAIL rxrst_strobes_now: got %b%b want 00",
                     data_is_valid, rx_error);
        end
        wait_cyc(t0 + (FB - 1) * CPB + CPB / 2);
        checks++;
        if (o_busy !== 1'b1 || serial_out !== 1'b1) begin
            errors++;
            $display("FAIL rxrst_tx_indep: got %b/%b want 1/1",
                     o_busy, serial_out);
        end
        reset_rx = 1'b0;
        wait_cyc(t0 + FB * CPB + CPB);
        checks++;
        if (n_valid !== nv0 || n_err !== ne0) begin
            errors++;
            $display("FAIL rxrst_no_strobe: got %0d/%0d want 0/0",
                     n_valid - nv0, n_err - ne0);
        end
        checks++;
        if (received_data !== model_last) begin
            errors++;
            $display("FAIL rxrst_hold: got %h want %h",
                     received_data, model_last);
        end
        test_frame(8'hA3, "after_rxrst");
    endtask

    task automatic test_stop_error();
        logic [7:0] d;
        int t0, nv0, ne0;
        d = model_last ^ 8'hFF;
        nv0 = n_valid;
        ne0 = n_err;
        @(negedge clk);
        i_data = d;
        enable = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        @(negedge clk);
        enable = 1'b0;
        wait_cyc(t0 + (FB - 1) * CPB);
        force dut.w_rx_line = 1'b0;
        wait_cyc(t0 + FB * CPB);
        release dut.w_rx_line;
        wait_cyc(t0 + FB * CPB + CPB);
        checks++;
        if (n_err !== ne0 + 1) begin
            errors++;
            $display("FAIL stop_err_count: got %0d want 1", n_err - ne0);
        end
        checks++;
        if (n_valid !== nv0) begin
            errors++;
            $display("FAIL stop_err_valid: got %0d want 0", n_valid - nv0);
        end
        checks++;
        if (received_data !== model_last) begin
            errors++;
            $display("FAIL stop_err_hold: got %h want %h",
                     received_data, model_last);
        end
`ifdef UART_PARITY_EN
        d = 8'($urandom);
        nv0 = n_valid;
        ne0 = n_err;
        @(negedge clk);
        i_data = d;
        enable = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        @(negedge clk);
        enable = 1'b0;
        wait_cyc(t0 + 3 * CPB);
        if (d[2]) force dut.w_rx_line = 1'b0;
        else force dut.w_rx_line = 1'b1;
        wait_cyc(t0 + 4 * CPB);
        release dut.w_rx_line;
        wait_cyc(t0 + FB * CPB + CPB);
        checks++;
        if (n_err !== ne0 + 1 || n_valid !== nv0) begin
            errors++;
            $display("FAIL parity_err: got %0d/%0d want 1/0",
                     n_err - ne0, n_valid - nv0);
        end
        checks++;
        if (received_data !== model_last) begin
            errors++;
            $display("FAIL parity_hold: got %h want %h",
                     received_data, model_last);
        end
`endif
    endtask

    task automatic test_glitch();
        int nv0, ne0;
        nv0 = n_valid;
        ne0 = n_err;
        wait_cyc(cyc + 2);
        force dut.w_rx_line = 1'b0;
        wait_cyc(cyc + (3 * CPB) / 10);
        release dut.w_rx_line;
        wait_cyc(cyc + 2 * CPB);
        checks++;
        if (n_valid !== nv0 || n_err !== ne0) begin
            errors++;
            $display("FAIL glitch_strobe: got %0d/%0d want 0/0",
                     n_valid - nv0, n_err - ne0);
        end
        checks++;
        if (received_data !== model_last) begin
            errors++;
            $display("FAIL glitch_hold: got %h want %h",
                     received_data, model_last);
        end
        test_frame(8'($urandom), "after_glitch");
    endtask

    initial begin
        test_reset();
        test_frame(8'hA3, "basic");
        test_random_frames();
        test_back_to_back();
        test_tx_reset();
        test_rx_reset();
        test_stop_error();
        test_glitch();
        checks++;
        if (n_wide !== 0) begin
            errors++;
            $display("FAIL strobe_width: got %0d wide strobes want 0",
                     n_wide);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/test_uart.md
TEST_UART -- requirements
Module: test_uart

Interface
REQ-001 SHALL have parameter INPUT_DATA_WIDTH, default 8, meaning the data bits per frame.
REQ-002 SHALL have parameter CLOCKS_PER_BIT, default 868, meaning clk cycles per bit (115200 baud at 100 MHz); minimum value 4.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-004 SHALL have port reset_tx, input, 1 bit: transmitter reset, asynchronous, active-high.
REQ-005 SHALL have port reset_rx, input, 1 bit: receiver reset, asynchronous, active-high.
REQ-006 SHALL have port enable, input, 1 bit: transmit request.
REQ-007 SHALL have port i_data, input, INPUT_DATA_WIDTH bits: word to transmit.
REQ-008 SHALL have port serial_out, output, 1 bit: TX line, idle high.
REQ-009 SHALL have port o_busy, output, 1 bit: transmitter frame in progress.
REQ-010 SHALL have port received_data, output, INPUT_DATA_WIDTH bits: last good received word.
REQ-011 SHALL have port data_is_valid, output, 1 bit: one-cycle strobe, new received_data.
REQ-012 SHALL have port rx_error, output, 1 bit: one-cycle strobe, framing (or parity) error.

Function
REQ-013 SHALL contain a TX and an RX; the RX input SHALL be internally looped back from serial_out.
REQ-014 TX states SHALL be IDLE, START, DATA, STOP (plus PARITY when enabled), each bit lasting exactly CLOCKS_PER_BIT cycles.
REQ-015 In IDLE, enable=1 sampled at edge N SHALL latch i_data and drive serial_out=0 and o_busy=1 from edge N+1.
REQ-016 Frame SHALL be start bit 0, data bits LSB first, stop bit 1; o_busy SHALL drop to 0 after the last stop-bit cycle.
REQ-017 i_data changes while o_busy=1 SHALL NOT affect the current frame.
REQ-018 enable held at 1 SHALL produce back-to-back frames with no idle cycle; enable=0 in IDLE SHALL keep serial_out=1.
REQ-019 RX SHALL pass the line through a 2-flop synchronizer.
REQ-020 RX states SHALL be IDLE, START, DATA, STOP (plus PARITY when enabled).
REQ-021 RX SHALL leave IDLE on a synchronized falling edge.
REQ-022 RX SHALL sample at mid-bit (CLOCKS_PER_BIT/2 cycles into the start bit, then every CLOCKS_PER_BIT cycles).
REQ-023 A start bit that reads 1 at mid-bit SHALL return RX to IDLE with no strobe.
REQ-024 Stop bit read as 1 SHALL update received_data and pulse data_is_valid for exactly one cycle at the stop-bit sample.
REQ-025 Stop bit read as 0 SHALL pulse rx_error for one cycle and leave received_data unchanged.
REQ-026 After any strobe RX SHALL return to IDLE and accept a start edge immediately.
REQ-027 data_is_valid SHALL occur within 9.5*CLOCKS_PER_BIT+4 cycles of serial_out falling.
REQ-028 Truncated frames SHALL be received as-is: the line reads 1 after a TX reset.

Reset
REQ-029 reset_tx=1 SHALL immediately force serial_out=1, o_busy=0, TX state IDLE and counters 0, including mid-frame.
REQ-030 reset_rx=1 SHALL immediately force received_data=0, data_is_valid=0, rx_error=0, RX state IDLE and synchronizer flops to 1.
REQ-031 Resets SHALL be independent: reset_tx SHALL NOT affect RX state and reset_rx SHALL NOT affect TX state.
REQ-032 After deassertion, TX SHALL accept enable on the first clk edge.

Configuration
REQ-033 With UART_PARITY_EN defined, TX SHALL insert an even-parity bit between the data and stop bits (11-bit frame).
REQ-034 With UART_PARITY_EN defined, RX SHALL check parity; on mismatch it SHALL pulse rx_error, suppress data_is_valid and leave received_data unchanged.
REQ-035 Without UART_PARITY_EN the frame SHALL be 10 bits and there SHALL be no parity logic.

Verification
REQ-036 Reset release, i_data=0xA3, enable=1 -> serial_out bits 0,1,1,0,0,0,1,0,1,1, each 868 cycles; data_is_valid pulse; received_data=0xA3.
REQ-037 enable held 1 for 3 frames -> o_busy stays 1 across frames; three data_is_valid pulses, each with 0xA3.
REQ-038 reset_tx pulsed mid data bit 3 -> serial_out=1 and o_busy=0 within the reset cycle; RX raises data_is_valid with the upper bits reading 1, with no hang.
REQ-039 reset_rx pulsed mid-frame -> received_data=0 and no strobes; the next full frame gives received_data=0xA3.
REQ-040 Line forced low through the stop-bit sample (via force) -> rx_error one-cycle pulse, received_data unchanged; with UART_PARITY_EN, one corrupted data bit -> rx_error.
REQ-041 0.3-bit glitch low on idle line -> no strobe; RX back in IDLE.
